// File: rtl/iddr_deser_pkg.sv
// rtl/iddr_deser_pkg.sv - shared types and width helpers for the DDR deserialiser
package iddr_deser_pkg;

    // Per-lane word alignment state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    // Width of a bit offset / slip count in 0..ratio-1 (at least one bit)
    function automatic int offset_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    // Width of a counter that must hold the value holdoff itself
    function automatic int holdoff_width(input int holdoff);
        return $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/iddr_deser_lane.sv
// rtl/iddr_deser_lane.sv - one lane: DDR capture, history, offset mux, slip holdoff, align FSM
//  clk/rst    capture clock (both edges sample d), async active-high reset
//  d          DDR serial input bit
//  bitslip    manual slip pulse
//  align_en   auto-align mode enable
//  wrap       shared cadence wrap: register the next word this edge
//  beat       shared out_valid currently high
//  word       registered RATIO-bit word, earliest bit at bit 0
//  slip_busy  holdoff after a slip, locked / align_err from the align FSM
module iddr_deser_lane
    import iddr_deser_pkg::*;
#(
    parameter int              RATIO         = 8,
    parameter int              SLIP_HOLDOFF  = 2,
    parameter logic [RATIO-1:0] ALIGN_PATTERN = 8'hBC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             bitslip,
    input  logic             align_en,
    input  logic             wrap,
    input  logic             beat,
    output logic [RATIO-1:0] word,
    output logic             slip_busy,
    output logic             locked,
    output logic             align_err
);

    localparam int OFF_W  = offset_width(RATIO);
    localparam int HOLD_W = holdoff_width(SLIP_HOLDOFF);
    localparam logic [OFF_W-1:0] K_MAX   = OFF_W'(RATIO - 1);
    localparam logic [OFF_W:0]   RATIO_V = (OFF_W + 1)'(RATIO);
    localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(SLIP_HOLDOFF);

    logic                 rise_q;
    logic                 fall_q;
    logic [1:0]           pair_q;
    logic [2*RATIO-1:0]   hist;
    logic [OFF_W-1:0]     k;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [OFF_W-1:0]     slip_cnt;
    align_state_t         state;
    logic [OFF_W:0]       shamt;
    logic [RATIO-1:0]     window;
    logic                 busy;
    logic                 manual_slip;
    logic                 auto_slip;
    logic                 slip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rise_q <= 1'b0;
        else     rise_q <= d;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) fall_q <= 1'b0;
        else     fall_q <= d;
    end

    // Newest pair enters at the top, so the oldest history bit sits at bit 0.
    // The newest RATIO bits start at RATIO; offset k reaches k bits further back.
    assign shamt  = RATIO_V - {1'b0, k};
    assign window = hist[shamt +: RATIO];

    assign busy        = (hold_cnt != '0);
    assign slip_busy   = busy;
    assign manual_slip = bitslip && !align_en && !busy;
    assign auto_slip   = align_en && (state == ST_CHECK) && beat && (word != ALIGN_PATTERN);
    assign slip        = manual_slip || auto_slip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q   <= '0;
            hist     <= '0;
            word     <= '0;
            k        <= '0;
            hold_cnt <= '0;
        end else begin
            pair_q <= {fall_q, rise_q};
            hist   <= {pair_q, hist[2*RATIO-1:2]};
            if (wrap) word <= window;
            if (slip) begin
                k        <= (k == K_MAX) ? '0 : k + 1'b1;
                hold_cnt <= HOLD_V;
            end else if (busy && beat) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            slip_cnt  <= '0;
            locked    <= 1'b0;
            align_err <= 1'b0;
        end else if (!align_en) begin
            state     <= ST_IDLE;
            locked    <= 1'b0;
            align_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_CHECK;
                    slip_cnt <= '0;
                end
                ST_CHECK: begin
                    if (beat) begin
                        if (word == ALIGN_PATTERN) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            // A full revolution of offsets without a match
                            if (slip_cnt == K_MAX) begin
                                align_err <= 1'b1;
                                slip_cnt  <= '0;
                            end else begin
                                slip_cnt <= slip_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (!busy) state <= ST_CHECK;
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

endmodule

// File: rtl/iddr_deser.sv
// rtl/iddr_deser.sv - multi-lane DDR capture with 1:RATIO deserialiser, bitslip and auto-align
//  clk        capture and logic clock, both edges sample d
//  rst        asynchronous active-high reset
//  d          DDR serial data, one bit per lane
//  bitslip    manual slip pulse per lane
//  align_en   auto-align mode (manual bitslip ignored)
//  out_data   lane l word at [l*RATIO +: RATIO]
//  out_valid  1-cycle strobe every RATIO/2 cycles, common to all lanes
//  slip_busy / locked / align_err  per-lane status
module iddr_deser
    import iddr_deser_pkg::*;
#(
    parameter int               LANES         = 1,
    parameter int               RATIO         = 8,
    parameter int               SLIP_HOLDOFF  = 2,
    parameter logic [RATIO-1:0] ALIGN_PATTERN = 8'hBC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       d,
    input  logic [LANES-1:0]       bitslip,
    input  logic                   align_en,
    output logic [LANES*RATIO-1:0] out_data,
    output logic                   out_valid,
    output logic [LANES-1:0]       slip_busy,
    output logic [LANES-1:0]       locked,
    output logic [LANES-1:0]       align_err
);

    localparam int CNT_W = offset_width(RATIO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : cnt + 1'b1;
            out_valid <= wrap;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        iddr_deser_lane #(
            .RATIO         (RATIO),
            .SLIP_HOLDOFF  (SLIP_HOLDOFF),
            .ALIGN_PATTERN (ALIGN_PATTERN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .d         (d[l]),
            .bitslip   (bitslip[l]),
            .align_en  (align_en),
            .wrap      (wrap),
            .beat      (out_valid),
            .word      (out_data[l*RATIO +: RATIO]),
            .slip_busy (slip_busy[l]),
            .locked    (locked[l]),
            .align_err (align_err[l])
        );
    end

endmodule

// File: tb/tb_iddr_deser.sv
// tb/tb_iddr_deser.sv - self-checking bench for iddr_deser with a stream-level reference model
module tb_iddr_deser;

    localparam int LANES = 2;
    localparam int RATIO = 8;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  d;
    logic [1:0]  bitslip;
    logic        align_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  slip_busy;
    logic [1:0]  locked;
    logic [1:0]  align_err;

    iddr_deser #(
        .LANES         (LANES),
        .RATIO         (RATIO),
        .SLIP_HOLDOFF  (HOLD),
        .ALIGN_PATTERN (8'hBC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .bitslip   (bitslip),
        .align_en  (align_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .slip_busy (slip_busy),
        .locked    (locked),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw DDR bits per lane indexed from the first
    // rising edge after reset release (rise bit 2e, fall bit 2e+1).
    bit         raw [LANES][4096];
    int         edge_n;
    int         k_m [LANES];
    int         acc_edge [LANES];
    bit         acc_valid [LANES];
    bit         tracking;
    int         gen [LANES];
    logic [7:0] pat [LANES];
    int         sh [LANES];
    int         vcnt;
    int         busy_beats;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit gen_bit(input int l, input int i);
        logic [7:0] b;
        case (gen[l])
            1: begin b = pat[l]; return b[(i + 6 + sh[l]) % 8]; end
            2: begin b = 8'((i + 6) / 8 + 48); return b[(i + 6) % 8]; end
            3: return 1'($urandom);
            default: return 1'b0;
        endcase
    endfunction

    // A pair sampled at edge c is usable two edges later and the word is
    // registered one edge after that, so the word closed at cadence edge e
    // ends at raw bit 2*(e-3)+1, then reaches k bits further back.
    function automatic logic [7:0] exp_word(input int l, input int e);
        logic [7:0] w;
        int idx;
        for (int b = 0; b < 8; b++) begin
            idx = 2 * (e - 3) + 1 - 7 - k_m[l] + b;
            w[b] = (idx < 0) ? 1'b0 : raw[l][idx];
        end
        return w;
    endfunction

    // Busy after edge e: fewer than HOLD valid beats completed since acceptance
    function automatic bit busy_exp(input int l, input int e);
        int n;
        n = 0;
        if (!acc_valid[l]) return 1'b0;
        for (int w = acc_edge[l]; w <= e - 1; w++)
            if (w % 4 == 3) n++;
        return n < HOLD;
    endfunction

    task automatic cycle(input logic [1:0] slip);
        logic [1:0] rb;
        logic [1:0] fb;
        int e;
        bit acc;
        e = edge_n;
        for (int l = 0; l < LANES; l++) begin
            rb[l] = gen_bit(l, 2 * e);
            fb[l] = gen_bit(l, 2 * e + 1);
            raw[l][2 * e]     = rb[l];
            raw[l][2 * e + 1] = fb[l];
        end
        d       = rb;
        bitslip = slip;
        @(posedge clk);
        #1;
        d       = fb;
        bitslip = 2'b00;
        chk("out_valid", 32'(out_valid), 32'(e % 4 == 3));
        if (out_valid) vcnt++;
        if (out_valid && slip_busy[0]) busy_beats++;
        if (tracking && (e % 4 == 3)) begin
            for (int l = 0; l < LANES; l++)
                chk($sformatf("word lane%0d edge%0d", l, e), 32'(out_data[l*8 +: 8]), 32'(exp_word(l, e)));
        end
        for (int l = 0; l < LANES; l++) begin
            acc = slip[l] && !align_en && !busy_exp(l, e - 1);
            if (acc) begin
                k_m[l]       = (k_m[l] + 1) % RATIO;
                acc_edge[l]  = e;
                acc_valid[l] = 1'b1;
            end
            if (tracking) begin
                chk($sformatf("slip_busy lane%0d edge%0d", l, e), 32'(slip_busy[l]), 32'(busy_exp(l, e)));
                chk($sformatf("locked lane%0d", l), 32'(locked[l]), 32'd0);
            end
        end
        edge_n++;
        @(negedge clk);
        #1;
    endtask

    // Called at negedge+1 so no falling sample precedes the first rising edge
    task automatic release_reset();
        rst    = 1'b0;
        edge_n = 0;
        for (int l = 0; l < LANES; l++) begin
            k_m[l]       = 0;
            acc_valid[l] = 1'b0;
            acc_edge[l]  = 0;
        end
        tracking = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_data"}, 32'(out_data), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " slip_busy"}, 32'(slip_busy), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " align_err"}, 32'(align_err), 32'd0);
    endtask

    initial begin
        int n;
        int first_v;
        rst = 1'b1; d = '0; bitslip = '0; align_en = 1'b0;
        for (int l = 0; l < LANES; l++) begin gen[l] = 0; pat[l] = 8'h00; sh[l] = 0; end
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        release_reset();

        // 1: lane0 repeating 0xA5 on the word grid, lane1 idle
        gen[0] = 1; pat[0] = 8'hA5;
        vcnt = 0;
        repeat (24) cycle(2'b00);
        chk("t1 valid count", 32'(vcnt), 32'd6);
        chk("t1 lane0 word", 32'(out_data[7:0]), 32'hA5);
        chk("t1 lane1 word", 32'(out_data[15:8]), 32'h00);

        // 2/3: incrementing bytes on lane0, random lane1, slip then a dropped slip
        gen[0] = 2; gen[1] = 3;
        repeat (16) cycle(2'b00);
        busy_beats = 0;
        cycle(2'b01);
        repeat (2) cycle(2'b00);
        cycle(2'b01);
        repeat (24) cycle(2'b00);
        chk("t3 busy beats", 32'(busy_beats), 32'(HOLD));

        // 4: a full revolution of accepted slips on lane0
        for (int s = 0; s < 8; s++) begin
            cycle(2'b01);
            repeat (11) cycle(2'b00);
        end
        repeat (16) cycle(2'b00);

        // 5a: 0xBC stream with bit offsets, auto-align on both lanes
        tracking = 1'b0;
        gen[0] = 1; pat[0] = 8'hBC; sh[0] = 3;
        gen[1] = 1; pat[1] = 8'hBC; sh[1] = 6;
        repeat (8) cycle(2'b00);
        align_en = 1'b1;
        n = 0;
        while (locked !== 2'b11 && n < 250) begin cycle(2'b01); n++; end
        chk("t5 locked", 32'(locked), 32'h3);
        chk("t5 word at lock", 32'(out_data), 32'hBCBC);
        chk("t5 align_err", 32'(align_err), 32'h0);
        repeat (8) cycle(2'b00);
        chk("t5 locked held", 32'(locked), 32'h3);
        chk("t5 word held", 32'(out_data), 32'hBCBC);

        // 5b: stream without the pattern raises align_err, align_en=0 clears it
        align_en = 1'b0;
        cycle(2'b00);
        chk("t5b unlock", 32'(locked), 32'h0);
        pat[0] = 8'h5A; pat[1] = 8'h5A;
        repeat (12) cycle(2'b00);
        align_en = 1'b1;
        n = 0;
        while (align_err !== 2'b11 && n < 400) begin cycle(2'b00); n++; end
        chk("t5b align_err", 32'(align_err), 32'h3);
        chk("t5b not locked", 32'(locked), 32'h0);
        align_en = 1'b0;
        cycle(2'b00);
        chk("t5b err cleared", 32'(align_err), 32'h0);

        // 6: asynchronous reset mid-word, then first strobe on the 4th edge
        gen[0] = 3; gen[1] = 3;
        repeat (9) cycle(2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        #1;
        release_reset();
        first_v = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(2'b00);
            if (out_valid && first_v < 0) first_v = i;
        end
        chk("t6 first valid edge", 32'(first_v), 32'd3);
        repeat (16) cycle(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
